// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and the UART TX.
// The arbiter takes the slave view; the requester/serializer side takes master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_valid,
    input  tx_data,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_valid,
    output tx_data,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NUM_REQ byte streams.
// A grant stays locked for a whole message, a burst cap or a stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_TIMEOUT);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] gid;
  logic [IW-1:0] gid_n;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_ptr_n;
  logic [IW-1:0] pick;
  logic          found;
  logic [7:0]    burst_cnt;
  logic [7:0]    burst_n;
  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] stall_n;
  logic          g_valid;
  logic          g_last;
  logic [7:0]    g_data;
  logic          xfer;
  logic          cap_hit;
  logic          stall_hit;

  // First valid requester after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign g_valid   = bus.req_valid[gid];
  assign g_last    = bus.req_last[gid];
  assign g_data    = bus.req_data[8*int'(gid) +: 8];
  assign xfer      = (state == LOCK) && g_valid && bus.tx_ready;
  assign cap_hit   = burst_cnt == 8'(MAX_BURST - 1);
  assign stall_hit = stall_cnt == SW'(STALL_TIMEOUT - 1);

  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.req_ready = '0;
    bus.busy      = (state == LOCK);
    bus.grant_id  = gid;
    if (state == LOCK) begin
      bus.tx_valid       = g_valid;
      bus.tx_data        = g_data;
      bus.req_ready[gid] = bus.tx_ready;
    end
  end

  always_comb begin
    state_n  = state;
    gid_n    = gid;
    rr_ptr_n = rr_ptr;
    burst_n  = burst_cnt;
    stall_n  = stall_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          gid_n   = pick;
          burst_n = 8'd0;
          stall_n = '0;
          state_n = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          burst_n = burst_cnt + 8'd1;
          stall_n = '0;
          if (g_last || cap_hit) begin
            state_n  = IDLE;
            rr_ptr_n = gid;
          end
        end else if (!g_valid) begin
          // Held-valid under backpressure is not a stall.
          if (stall_hit) begin
            state_n  = IDLE;
            rr_ptr_n = gid;
          end else begin
            stall_n = stall_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gid       <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      burst_cnt <= 8'd0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      gid       <= gid_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_n;
      stall_cnt <= stall_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for one message, then queued
// requester streams checked against an expected-byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int ST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .MAX_BURST(MB),
    .STALL_TIMEOUT(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] d;
    logic       txr;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [3:0] exp_rdy;
    logic       exp_busy;
    logic [1:0] exp_gid;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  vec_t       tv [5];
  exp_t       sb [$];
  int         xcyc [$];
  logic [8:0] mem [N][32];
  int         hd [N];
  int         tl [N];
  logic [N-1:0] hs;
  logic [3:0] rdy_pat;
  bit         use_pat;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) p = 1'b1;
    return p;
  endfunction

  task automatic push_msg(input int id, input int n, input logic [7:0] base,
                          input bit last_end);
    for (int k = 0; k < n; k++) begin
      mem[id][tl[id]] = {last_end && (k == n - 1), base + 8'(k)};
      tl[id]++;
    end
  endtask

  task automatic ex(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [N*8-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (hd[i] != tl[i]) begin
        v[i]        = 1'b1;
        l[i]        = mem[i][hd[i]][8];
        d[8*i +: 8] = mem[i][hd[i]][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = use_pat ? rdy_pat[cyc % 4] : 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    if (!bus.tx_ready) check("bp_req_ready", 32'(bus.req_ready), 0);
    if (bus.tx_valid && bus.tx_ready) begin
      xcyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h want none", bus.tx_data);
      end else begin
        e = sb.pop_front();
        check("tx_data", 32'(bus.tx_data), 32'(e.data));
        check("grant_id", 32'(bus.grant_id), 32'(e.id));
        check("req_ready", 32'(bus.req_ready), 32'(1) << e.id);
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    if (!rst) monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) for (int i = 0; i < N; i++) if (hs[i]) hd[i]++;
  endtask

  task automatic run(input int budget, input bit sb_only, input string name);
    int k = 0;
    while ((sb.size() != 0 || (!sb_only && pending())) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d left want 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    sb.delete();
    xcyc.delete();
    use_pat = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 8'h48, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tv[1] = '{1'b1, 1'b0, 8'h48, 1'b1, 1'b1, 8'h48, 4'b0010, 1'b1, 2'd1};
    tv[2] = '{1'b1, 1'b0, 8'h69, 1'b1, 1'b1, 8'h69, 4'b0010, 1'b1, 2'd1};
    tv[3] = '{1'b1, 1'b1, 8'h0A, 1'b1, 1'b1, 8'h0A, 4'b0010, 1'b1, 2'd1};
    tv[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};

    do_reset();
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_busy", 32'(bus.busy), 0);

    // Single requester 1: grant after one cycle, 48 69 0A, then release.
    for (int r = 0; r < 5; r++) begin
      bus.req_valid = {2'b00, tv[r].v, 1'b0};
      bus.req_last  = {2'b00, tv[r].l, 1'b0};
      bus.req_data  = {16'h0000, tv[r].d, 8'h00};
      bus.tx_ready  = tv[r].txr;
      @(negedge clk);
      check($sformatf("tv%0d_tx_valid", r), 32'(bus.tx_valid), 32'(tv[r].exp_v));
      check($sformatf("tv%0d_tx_data", r), 32'(bus.tx_data), 32'(tv[r].exp_d));
      check($sformatf("tv%0d_req_ready", r), 32'(bus.req_ready), 32'(tv[r].exp_rdy));
      check($sformatf("tv%0d_busy", r), 32'(bus.busy), 32'(tv[r].exp_busy));
      check($sformatf("tv%0d_grant_id", r), 32'(bus.grant_id), 32'(tv[r].exp_gid));
      @(posedge clk);
      #1;
      cyc++;
    end

    // Contention: req0 fully, then req2; then rr_ptr=2 favours req0.
    do_reset();
    push_msg(0, 3, 8'hA0, 1'b1);
    push_msg(2, 3, 8'hB0, 1'b1);
    for (int k = 0; k < 3; k++) ex(0, 8'hA0 + 8'(k));
    for (int k = 0; k < 3; k++) ex(2, 8'hB0 + 8'(k));
    run(60, 1'b0, "contention");
    push_msg(0, 1, 8'hC0, 1'b1);
    push_msg(2, 1, 8'hD0, 1'b1);
    ex(0, 8'hC0);
    ex(2, 8'hD0);
    run(30, 1'b0, "contention2");

    // Burst cap: req3 cut after 4 bytes, req1 served, req3 resumes.
    do_reset();
    push_msg(3, 6, 8'hE0, 1'b0);
    step();
    push_msg(1, 2, 8'hF0, 1'b1);
    for (int k = 0; k < 4; k++) ex(3, 8'hE0 + 8'(k));
    ex(1, 8'hF0);
    ex(1, 8'hF1);
    ex(3, 8'hE4);
    ex(3, 8'hE5);
    run(80, 1'b0, "burst");
    repeat (ST - 1) step();
    check("stall_busy_hold", 32'(bus.busy), 1);
    step();
    check("stall_busy_drop", 32'(bus.busy), 0);

    // Backpressure: tx_ready 1,0,0,1 repeating over a 5-byte message.
    do_reset();
    use_pat = 1'b1;
    rdy_pat = 4'b1001;
    push_msg(2, 5, 8'h50, 1'b1);
    for (int k = 0; k < 5; k++) ex(2, 8'h50 + 8'(k));
    run(80, 1'b0, "backpressure");
    use_pat = 1'b0;

    // Stall timeout: req0 goes quiet after one byte, req1 waits.
    do_reset();
    push_msg(0, 1, 8'h60, 1'b0);
    push_msg(1, 1, 8'h70, 1'b1);
    ex(0, 8'h60);
    ex(1, 8'h70);
    run(60, 1'b0, "stall");
    check("stall_xfers", 32'(xcyc.size()), 2);
    if (xcyc.size() == 2) check("stall_gap", 32'(xcyc[1] - xcyc[0]), 10);

    // Mid-message reset after byte 2 of 5 from req2.
    do_reset();
    push_msg(2, 5, 8'h80, 1'b1);
    ex(2, 8'h80);
    ex(2, 8'h81);
    run(40, 1'b1, "midreset");
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    rst = 1'b0;
    drive();
    #1;
    check("mrst_tx_valid", 32'(bus.tx_valid), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_grant_id", 32'(bus.grant_id), 0);
    push_msg(0, 1, 8'h90, 1'b1);
    push_msg(3, 1, 8'h91, 1'b1);
    ex(0, 8'h90);
    ex(3, 8'h91);
    run(30, 1'b0, "midreset2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
